// File: rtl/dram_line_reader.sv
`default_nettype none
// ============================================================================
//  Module      : dram_line_reader
//  Description : AXI4 read engine feeding the hdmi_gen line FIFO. Accepts a
//                line-fetch request, splits it into INCR bursts that never
//                cross a 4 KiB page, and streams returned words out with a
//                one-cycle write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_line_reader #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kick,
    output logic              busy,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [31:0]       read_num,
    output logic [DATA_W-1:0] buf_dout,
    output logic              buf_we,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              rd_err
);

    localparam int c_LSB = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK =
        ~((ADDR_W'(1) << c_LSB) - ADDR_W'(1));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_kick_d;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_remaining;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [8:0]        r_beats;
    logic [8:0]        r_cnt;
    logic [DATA_W-1:0] r_buf_dout;
    logic              r_buf_we;
    logic              r_rd_err;

    logic              w_accept;
    logic              w_last_beat;
    logic [12:0]       w_page_words;
    logic [31:0]       w_beats;
    logic              w_busy;
    logic              w_arvalid;

    // Burst length is counted locally, so the slave's rlast is informational only.
    logic              w_unused_rlast;
    assign w_unused_rlast = m_axi_rlast;

    assign w_accept    = kick && !r_kick_d && (r_state == S_IDLE);
    assign w_last_beat = (r_cnt == r_beats - 9'd1);

    // Burst size: the smallest of words left, burst cap and words left in the 4 KiB page.
    always_comb begin
        w_page_words = (13'd4096 - {1'b0, r_addr[11:0]}) >> c_LSB;
        w_beats      = r_remaining;
        if (w_beats > 32'(MAX_BURST)) begin
            w_beats = 32'(MAX_BURST);
        end
        if (w_beats > {19'd0, w_page_words}) begin
            w_beats = {19'd0, w_page_words};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_arvalid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = (r_remaining == 32'd0) ? S_DONE : S_ADDR;
            end
            S_ADDR: begin
                w_arvalid = 1'b1;
                if (m_axi_arready) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axi_rvalid && w_last_beat) begin
                    w_state_next = (r_remaining == {23'd0, r_beats}) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request capture, burst bookkeeping and word forwarding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kick_d    <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_beats     <= '0;
            r_cnt       <= '0;
            r_buf_dout  <= '0;
            r_buf_we    <= 1'b0;
            r_rd_err    <= 1'b0;
        end else begin
            r_kick_d <= kick;
            r_buf_we <= 1'b0;
            if (m_axi_rvalid && (m_axi_rresp != 2'b00)) begin
                r_rd_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= read_addr & c_ALIGN_MASK;
                        r_remaining <= read_num;
                    end
                end
                S_CALC: begin
                    if (r_remaining != 32'd0) begin
                        r_araddr <= r_addr;
                        r_arlen  <= w_beats[7:0] - 8'd1;
                        r_beats  <= w_beats[8:0];
                        r_cnt    <= '0;
                    end
                end
                S_DATA: begin
                    if (m_axi_rvalid) begin
                        r_buf_dout <= m_axi_rdata;
                        r_buf_we   <= 1'b1;
                        r_cnt      <= r_cnt + 9'd1;
                        if (w_last_beat) begin
                            r_addr      <= r_addr + (ADDR_W'(r_beats) << c_LSB);
                            r_remaining <= r_remaining - {23'd0, r_beats};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = w_busy;
    assign m_axi_arvalid = w_arvalid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'(c_LSB);
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = 1'b1;
    assign buf_dout      = r_buf_dout;
    assign buf_we        = r_buf_we;
    assign rd_err        = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_line_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_line_reader
//  Description : Bench for dram_line_reader with an AXI slave/memory model and
//                a burst-splitting reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_line_reader;

    logic        clk;
    logic        rst;
    logic        kick;
    logic        busy;
    logic [31:0] read_addr;
    logic [31:0] read_num;
    logic [31:0] buf_dout;
    logic        buf_we;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        rd_err;

    dram_line_reader #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(64)) dut (
        .clk(clk), .rst(rst), .kick(kick), .busy(busy),
        .read_addr(read_addr), .read_num(read_num),
        .buf_dout(buf_dout), .buf_we(buf_we),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .rd_err(rd_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Slave configuration
    int ar_stall = 0;
    int r_stall  = 0;
    int err_at   = -1;
    int beat_total = 0;

    // Slave burst queue
    logic [31:0] sq_addr[$];
    logic [7:0]  sq_len[$];
    int          beat_idx = 0;

    // Observations
    logic [39:0] obs_ar[$];
    logic [31:0] obs_w[$];
    logic [39:0] exp_ar[$];
    logic [31:0] exp_w[$];
    int first_busy, busy_fall, first_arv, last_we, last_beat;
    int busy_rises, busy_cycles, arv_cycles;
    int kick_cyc;

    logic        p_arv = 1'b0;
    logic [31:0] p_araddr = '0;
    logic [7:0]  p_arlen = '0;
    logic        p_rst = 1'b1;
    logic        p_busy = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // AXI slave + monitor, all at the falling edge
    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (p_arv && m_axi_arready && !p_rst) begin
                obs_ar.push_back({p_araddr, p_arlen});
                sq_addr.push_back(p_araddr);
                sq_len.push_back(p_arlen);
            end
            if (m_axi_rvalid && m_axi_rready) begin
                last_beat = cyc - 1;
                beat_total++;
                if (beat_idx >= int'(sq_len[0])) begin
                    void'(sq_addr.pop_front());
                    void'(sq_len.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            if (p_arv && !m_axi_arready && !p_rst && !rst) begin
                n_checks++;
                if (!(m_axi_arvalid === 1'b1 && m_axi_araddr === p_araddr && m_axi_arlen === p_arlen)) begin
                    n_fail++;
                    $display("FAIL ar_stable: got valid=%0b addr=%h len=%0d required valid=1 addr=%h len=%0d",
                             m_axi_arvalid, m_axi_araddr, m_axi_arlen, p_araddr, p_arlen);
                end
            end
            if (buf_we) begin
                obs_w.push_back(buf_dout);
                last_we = cyc;
            end
            if (busy && !p_busy) busy_rises++;
            if (busy) begin
                busy_cycles++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (!busy && p_busy) busy_fall = cyc;
            if (m_axi_arvalid) begin
                arv_cycles++;
                if (first_arv < 0) first_arv = cyc;
            end
            p_arv    = m_axi_arvalid;
            p_araddr = m_axi_araddr;
            p_arlen  = m_axi_arlen;
            p_rst    = rst;
            p_busy   = busy;
            m_axi_arready = (int'($urandom_range(99)) >= ar_stall);
            if (sq_addr.size() > 0 && int'($urandom_range(99)) >= r_stall) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = mem_word(sq_addr[0] + 32'(beat_idx * 4));
                m_axi_rlast  = (beat_idx == int'(sq_len[0]));
                m_axi_rresp  = (beat_total == err_at) ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rdata  = '0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
        end
    end

    // Reference: split the request with plain page/burst arithmetic
    task automatic build_expect(input logic [31:0] addr, input int unsigned num);
        logic [31:0] a;
        logic [31:0] base;
        longint unsigned rem, b, pg;
        exp_ar.delete();
        exp_w.delete();
        base = addr & 32'hFFFF_FFFC;
        a    = base;
        rem  = num;
        while (rem > 0) begin
            pg = (4096 - (longint'(a) % 4096)) / 4;
            b  = rem;
            if (b > 64) b = 64;
            if (b > pg) b = pg;
            exp_ar.push_back({a, 8'(b - 1)});
            a   = a + 32'(b * 4);
            rem = rem - b;
        end
        for (int unsigned i = 0; i < num; i++) exp_w.push_back(mem_word(base + 32'(i * 4)));
    endtask

    task automatic clear_obs();
        obs_ar.delete();
        obs_w.delete();
        first_busy = -1; busy_fall = -1; first_arv = -1;
        last_we = -1; last_beat = -1;
        busy_rises = 0; busy_cycles = 0; arv_cycles = 0;
        beat_total = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, buf_we, m_axi_arvalid, rd_err, m_axi_rready} !== 5'b00001 ||
            m_axi_araddr !== 32'd0 || m_axi_arlen !== 8'd0 || buf_dout !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_vals: got busy=%0b we=%0b arv=%0b err=%0b rready=%0b addr=%h len=%0d dout=%h required 0,0,0,0,1,0,0,0",
                     busy, buf_we, m_axi_arvalid, rd_err, m_axi_rready, m_axi_araddr, m_axi_arlen, buf_dout);
        end
        n_checks++;
        if (m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01) begin
            n_fail++;
            $display("FAIL ar_const: got size=%0d burst=%0d required 2,1", m_axi_arsize, m_axi_arburst);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_transfer(input logic [31:0] addr, input int unsigned num, input int ars,
                                 input int rs, input int eb, input logic exp_err, input string name);
        int wd;
        int idx;
        ar_stall = ars; r_stall = rs; err_at = eb;
        build_expect(addr, num);
        @(negedge clk);
        clear_obs();
        read_addr = addr; read_num = num; kick = 1'b1; kick_cyc = cyc;
        @(negedge clk);
        kick = 1'b0;
        wd = 0;
        while (busy_fall < 0 && wd < 20000) begin
            @(negedge clk);
            wd++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wd >= 20000) begin
            n_fail++;
            $display("FAIL %s timeout: busy never fell within %0d cycles", name, wd);
        end
        idx = -1;
        for (int i = 0; i < exp_ar.size(); i++)
            if (idx < 0 && (i >= obs_ar.size() || obs_ar[i] !== exp_ar[i])) idx = i;
        n_checks++;
        if (obs_ar.size() != exp_ar.size() || idx >= 0) begin
            n_fail++;
            $display("FAIL %s bursts: got %0d bursts (first bad %0d: %h) required %0d (%h)", name,
                     obs_ar.size(), idx, (idx >= 0 && idx < obs_ar.size()) ? obs_ar[idx] : 40'd0,
                     exp_ar.size(), (idx >= 0) ? exp_ar[idx] : 40'd0);
        end
        idx = -1;
        for (int i = 0; i < exp_w.size(); i++)
            if (idx < 0 && (i >= obs_w.size() || obs_w[i] !== exp_w[i])) idx = i;
        n_checks++;
        if (obs_w.size() != exp_w.size() || idx >= 0) begin
            n_fail++;
            $display("FAIL %s words: got %0d words (first bad %0d: %h) required %0d (%h)", name,
                     obs_w.size(), idx, (idx >= 0 && idx < obs_w.size()) ? obs_w[idx] : 32'd0,
                     exp_w.size(), (idx >= 0) ? exp_w[idx] : 32'd0);
        end
        n_checks++;
        if (first_busy - kick_cyc != 1 || first_arv - kick_cyc != 2) begin
            n_fail++;
            $display("FAIL %s kick_latency: got busy +%0d arvalid +%0d required +1 +2", name,
                     first_busy - kick_cyc, first_arv - kick_cyc);
        end
        n_checks++;
        if (last_we - last_beat != 1 || busy_fall - last_beat != 2) begin
            n_fail++;
            $display("FAIL %s end_latency: got last_we +%0d busy_low +%0d required +1 +2", name,
                     last_we - last_beat, busy_fall - last_beat);
        end
        n_checks++;
        if (rd_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s rd_err: got %0b required %0b", name, rd_err, exp_err);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        clear_obs();
        read_addr = 32'h3000_0100; read_num = 0; kick = 1'b1; kick_cyc = cyc;
        @(negedge clk);
        kick = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy_cycles != 2 || first_busy - kick_cyc != 1) begin
            n_fail++;
            $display("FAIL zero_busy: got %0d cycles starting +%0d required 2 starting +1",
                     busy_cycles, first_busy - kick_cyc);
        end
        n_checks++;
        if (arv_cycles != 0 || obs_w.size() != 0) begin
            n_fail++;
            $display("FAIL zero_traffic: got arvalid cycles=%0d words=%0d required 0 0", arv_cycles, obs_w.size());
        end
    endtask

    task automatic test_kick_held();
        ar_stall = 0; r_stall = 0; err_at = -1;
        build_expect(32'h2000_0040, 20);
        @(negedge clk);
        clear_obs();
        read_addr = 32'h2000_0040; read_num = 20; kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        @(negedge clk);
        kick = 1'b1;
        repeat (300) @(negedge clk);
        kick = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy_rises != 1) begin
            n_fail++;
            $display("FAIL held_requests: got %0d busy periods required 1", busy_rises);
        end
        n_checks++;
        if (obs_ar.size() != exp_ar.size() || obs_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL held_counts: got %0d bursts %0d words required %0d %0d",
                     obs_ar.size(), obs_w.size(), exp_ar.size(), exp_w.size());
        end else begin
            n_checks++;
            if (obs_ar[0] !== exp_ar[0] || obs_w[19] !== exp_w[19]) begin
                n_fail++;
                $display("FAIL held_content: got %h/%h required %h/%h", obs_ar[0], obs_w[19], exp_ar[0], exp_w[19]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int wd;
        ar_stall = 0; r_stall = 30; err_at = -1;
        @(negedge clk);
        clear_obs();
        read_addr = 32'h4000_0000; read_num = 300; kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        wd = 0;
        while (obs_w.size() < 20 && wd < 2000) begin
            @(negedge clk);
            wd++;
        end
        n_checks++;
        if (wd >= 2000) begin
            n_fail++;
            $display("FAIL rstmid_start: got %0d words required 20 before reset", obs_w.size());
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, buf_we, m_axi_arvalid, rd_err, m_axi_rready} !== 5'b00001 ||
            m_axi_araddr !== 32'd0 || m_axi_arlen !== 8'd0 || buf_dout !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got busy=%0b we=%0b arv=%0b err=%0b rready=%0b addr=%h len=%0d required 0,0,0,0,1,0,0",
                     busy, buf_we, m_axi_arvalid, rd_err, m_axi_rready, m_axi_araddr, m_axi_arlen);
        end
        rst = 1'b0;
        obs_w.delete();
        wd = 0;
        while (sq_addr.size() > 0 && wd < 2000) begin
            @(negedge clk);
            wd++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_w.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stray: got %0d words busy=%0b required 0 words busy=0", obs_w.size(), busy);
        end
    endtask

    initial begin
        rst = 1'b1; kick = 1'b0; read_addr = '0; read_num = '0;
        clear_obs();
        test_reset();
        test_transfer(32'h1000_0000, 1280, 0, 0, -1, 1'b0, "t1_long");
        test_transfer(32'h0000_0FC0, 40, 0, 0, -1, 1'b0, "t2_4k_split");
        test_zero();
        test_kick_held();
        test_transfer(32'h5000_0E13, 200, 40, 40, 7, 1'b1, "t5_stall_err");
        test_transfer(32'h5100_0000, 30, 20, 20, -1, 1'b1, "t5_sticky");
        for (int k = 0; k < 4; k++) begin
            test_transfer({$urandom(), 12'h000} | 32'($urandom_range(4095)),
                          $urandom_range(300, 1), 30, 30, -1, 1'b1, "random");
        end
        test_reset_mid();
        test_transfer(32'h6000_0FF8, 100, 20, 20, -1, 1'b0, "t6_after_rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
